dmem_arbiter: RTL and testbench

//  Shares the single Data_Memory port between the CPU MEM stage and a debug/loader requester.

---
 rtl/dmem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU MEM stage
// and a debug/loader requester. Each access runs IDLE -> ISSUE -> RESP (or
// IDLE -> RESP for illegal addresses), with a one-cycle registered ack pulse.
// The CPU pipeline is frozen by cpu_stall_o while its request is outstanding.
//
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration when
// both requesters are pending in IDLE. Without it, the CPU always wins.
module dmem_arbiter #(
    parameter int AW          = 8,
    parameter int DEPTH_BYTES = 32,
    parameter int TIMEOUT     = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [31:0]   cpu_wdata_i,
    output logic [31:0]   cpu_rdata_o,
    output logic          cpu_ack_o,
    output logic          cpu_err_o,
    output logic          cpu_stall_o,

    input  logic          dbg_req_i,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [31:0]   dbg_wdata_i,
    output logic [31:0]   dbg_rdata_o,
    output logic          dbg_ack_o,
    output logic          dbg_err_o,

    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,
    input  logic          mem_ack_i,

    output logic [1:0]    grant_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [1:0]  OWN_NONE  = 2'b00;
    localparam logic [1:0]  OWN_CPU   = 2'b01;
    localparam logic [1:0]  OWN_DBG   = 2'b10;
    // Last ISSUE cycle allowed before giving up; only meaningful when TIMEOUT != 0.
    localparam logic [3:0]  TO_LAST   = 4'(TIMEOUT - 1);
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_BYTES);
    localparam bit          TO_EN     = (TIMEOUT != 0);

    // Registered transaction context.
    state_t         state_q, state_d;
    logic [1:0]     owner_q, owner_d;
    logic           we_q, we_d;
    logic [AW-3:0]  waddr_q, waddr_d;    // word index; low two bits are always 0 on the bus
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;

    // Arbitration result and the selected requester's payload.
    logic           pick_dbg;
    logic           any_req;
    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [31:0]    sel_wdata;
    logic [31:0]    sel_addr_ext;
    logic           sel_bad;

`ifdef DMEM_ARB_RR_EN
    logic           last_dbg_q;          // 1 = debug was granted most recently

    // Remember who won the last grant so a tie goes to the other side next time.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            last_dbg_q <= 1'b1;
        else if (state_q == IDLE && any_req)
            last_dbg_q <= pick_dbg;
    end
`endif

    // Pick a winner among pending requests and mux its payload.
    always_comb begin
        any_req = cpu_req_i | dbg_req_i;
`ifdef DMEM_ARB_RR_EN
        pick_dbg = dbg_req_i & (~cpu_req_i | ~last_dbg_q);
`else
        pick_dbg = dbg_req_i & ~cpu_req_i;
`endif
        sel_we       = pick_dbg ? dbg_we_i    : cpu_we_i;
        sel_addr     = pick_dbg ? dbg_addr_i  : cpu_addr_i;
        sel_wdata    = pick_dbg ? dbg_wdata_i : cpu_wdata_i;
        sel_addr_ext = 32'(sel_addr);
        sel_bad      = (sel_addr[1:0] != 2'b00) || (sel_addr_ext >= DEPTH_LIM);
    end

    // Next-state logic: grant in IDLE, wait for memory in ISSUE, pulse in RESP.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (any_req) begin
                    owner_d = pick_dbg ? OWN_DBG : OWN_CPU;
                    we_d    = sel_we;
                    waddr_d = sel_addr[AW-1:2];
                    wdata_d = sel_wdata;
                    if (sel_bad) begin
                        // Illegal address: answer with an error, never touch memory.
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        state_d = ISSUE;
                        err_d   = 1'b0;
                        rdata_d = 32'd0;
                    end
                end
            end

            ISSUE: begin
                if (mem_ack_i) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : mem_rdata_i;
                    cnt_d   = 4'd0;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
                err_d   = 1'b0;
                rdata_d = 32'd0;
            end

            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // State and context registers; reset abandons any transaction without an ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'd0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode purely from registers, so the responses are clean pulses.
    always_comb begin
        cpu_ack_o   = (state_q == RESP) && (owner_q == OWN_CPU);
        dbg_ack_o   = (state_q == RESP) && (owner_q == OWN_DBG);
        cpu_err_o   = cpu_ack_o & err_q;
        dbg_err_o   = dbg_ack_o & err_q;
        cpu_rdata_o = cpu_ack_o ? rdata_q : 32'd0;
        dbg_rdata_o = dbg_ack_o ? rdata_q : 32'd0;

        mem_req_o   = (state_q == ISSUE);
        mem_we_o    = mem_req_o & we_q;
        mem_addr_o  = mem_req_o ? {waddr_q, 2'b00} : '0;
        mem_wdata_o = mem_req_o ? wdata_q : 32'd0;

        grant_o     = owner_q;
        busy_o      = (state_q != IDLE);
    end

    // Pipeline freeze: combinational so the CPU releases in the ack cycle itself.
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

    // Only one requester is ever answered at a time.
    a_one_ack: assert property (@(posedge clk_i) disable iff (rst_i)
        !(cpu_ack_o && dbg_ack_o));

    // A memory request always belongs to a granted owner.
    a_req_owned: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_req_o |-> (grant_o == OWN_CPU || grant_o == OWN_DBG));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// sweep, checked against a word-array memory model and timing rules.
module tb_dmem_arbiter;

    localparam int AW      = 8;
    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 0, cpu_we = 0;
    logic [7:0]  cpu_addr = 0;
    logic [31:0] cpu_wdata = 0;
    logic [31:0] cpu_rdata_o;
    logic        cpu_ack_o, cpu_err_o, cpu_stall_o;
    logic        dbg_req = 0, dbg_we = 0;
    logic [7:0]  dbg_addr = 0;
    logic [31:0] dbg_wdata = 0;
    logic [31:0] dbg_rdata_o;
    logic        dbg_ack_o, dbg_err_o;
    logic        mem_req_o, mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 0;
    logic        mem_ack_i = 0;
    logic [1:0]  grant_o;
    logic        busy_o;

    int npass = 0;
    int ncheck = 0;

    // Memory contents seen by the responder, and the expected contents.
    logic [31:0] mem     [8];
    logic [31:0] exp_mem [8];
    int          mem_delay = 0;   // ISSUE cycles before ack; negative = never ack
    int          issue_cnt = 0;

    dmem_arbiter #(.AW(AW), .DEPTH_BYTES(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata_o), .cpu_ack_o(cpu_ack_o),
        .cpu_err_o(cpu_err_o), .cpu_stall_o(cpu_stall_o),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o),
        .dbg_err_o(dbg_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after mem_delay ISSUE cycles, stable until next negedge.
    always @(negedge clk) begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;
        if (mem_req_o) begin
            if (mem_delay >= 0 && issue_cnt == mem_delay) begin
                mem_ack_i = 1'b1;
                if (mem_we_o) mem[mem_addr_o[4:2]] = mem_wdata_o;
                else          mem_rdata_i = mem[mem_addr_o[4:2]];
            end
            issue_cnt++;
        end else begin
            issue_cnt = 0;
        end
    end

    // One complete transaction from one requester, checked against the model.
    task automatic run_txn(input bit dbg, input bit we, input logic [7:0] addr,
                           input logic [31:0] wdata, input int delay, input string tag);
        bit bad, exp_err, got, issue_ok, stall_ok, cross_ack, ack, stall_at_ack;
        int exp_k, exp_reqc, k, reqc;
        logic [31:0] exp_rd, rd;
        logic [1:0]  exp_gnt;
        logic        err;
        bad      = (addr[1:0] != 2'b00) || (addr >= 8'd32);
        exp_err  = bad || (delay < 0);
        exp_rd   = (exp_err || we) ? 32'd0 : exp_mem[addr[4:2]];
        if (!exp_err && we) exp_mem[addr[4:2]] = wdata;
        exp_k    = bad ? 1 : ((delay < 0) ? TIMEOUT + 1 : delay + 2);
        exp_reqc = bad ? 0 : ((delay < 0) ? TIMEOUT : delay + 1);
        exp_gnt  = dbg ? 2'b10 : 2'b01;
        mem_delay = delay;
        @(posedge clk); #1;
        if (dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
        else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
        got = 0; k = 0; reqc = 0; issue_ok = 1; stall_ok = 1; cross_ack = 0;
        rd = 32'd0; err = 1'b0; stall_at_ack = 1'b1;
        while (!got && k < 64) begin
            @(negedge clk);
            if (mem_req_o) begin
                reqc++;
                if (mem_addr_o !== {addr[7:2], 2'b00} || mem_we_o !== we ||
                    (we && mem_wdata_o !== wdata) || grant_o !== exp_gnt) issue_ok = 0;
            end
            if (dbg ? cpu_ack_o : dbg_ack_o) cross_ack = 1;
            ack = dbg ? dbg_ack_o : cpu_ack_o;
            if (ack) begin
                got = 1;
                rd  = dbg ? dbg_rdata_o : cpu_rdata_o;
                err = dbg ? dbg_err_o : cpu_err_o;
                stall_at_ack = cpu_stall_o;
            end else begin
                if (!dbg && cpu_stall_o !== 1'b1) stall_ok = 0;
                k++;
            end
        end
        ncheck++;
        if (!got || k != exp_k) $display("FAIL %s latency: got=%0d ack_cycle=%0d want=%0d", tag, got, k, exp_k);
        else npass++;
        ncheck++;
        if (err !== exp_err) $display("FAIL %s err: got=%b want=%b", tag, err, exp_err);
        else npass++;
        ncheck++;
        if (rd !== exp_rd) $display("FAIL %s rdata: got=%h want=%h", tag, rd, exp_rd);
        else npass++;
        ncheck++;
        if (reqc != exp_reqc || !issue_ok)
            $display("FAIL %s mem_req: cycles=%0d want=%0d payload_ok=%b", tag, reqc, exp_reqc, issue_ok);
        else npass++;
        ncheck++;
        if (cross_ack) $display("FAIL %s other ack: got=1 want=0", tag);
        else npass++;
        if (!dbg) begin
            ncheck++;
            if (!stall_ok || stall_at_ack !== 1'b0)
                $display("FAIL %s stall: before_ack_ok=%b at_ack=%b want 1/0", tag, stall_ok, stall_at_ack);
            else npass++;
        end
        @(posedge clk); #1;
        if (dbg) dbg_req = 0; else cpu_req = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        ncheck++;
        if ({cpu_ack_o, cpu_err_o, dbg_ack_o, dbg_err_o} !== 4'b0)
            $display("FAIL reset acks: got=%b want=0000", {cpu_ack_o, cpu_err_o, dbg_ack_o, dbg_err_o});
        else npass++;
        ncheck++;
        if ((cpu_rdata_o | dbg_rdata_o) !== 32'd0)
            $display("FAIL reset rdata: cpu=%h dbg=%h want 0", cpu_rdata_o, dbg_rdata_o);
        else npass++;
        ncheck++;
        if ({mem_req_o, mem_we_o} !== 2'b00 || mem_addr_o !== 8'd0 || mem_wdata_o !== 32'd0)
            $display("FAIL reset mem port: req=%b we=%b addr=%h wdata=%h want 0", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
        else npass++;
        ncheck++;
        if (grant_o !== 2'b00 || busy_o !== 1'b0 || cpu_stall_o !== 1'b0)
            $display("FAIL reset status: grant=%b busy=%b stall=%b want 0", grant_o, busy_o, cpu_stall_o);
        else npass++;
    endtask

    task automatic test_cpu_load();
        mem[1] = 32'h0000_000A; exp_mem[1] = 32'h0000_000A;
        run_txn(0, 0, 8'h04, 32'd0, 0, "cpu_load");
    endtask

    task automatic test_dbg_store();
        run_txn(1, 1, 8'h00, 32'h0000_0005, 3, "dbg_store");
        run_txn(0, 0, 8'h00, 32'd0, 0, "readback");
    endtask

    task automatic test_errors();
        run_txn(0, 0, 8'h06, 32'd0, 0, "misaligned");
        run_txn(0, 0, 8'h20, 32'd0, 0, "out_of_range");
        run_txn(1, 1, 8'h21, 32'hDEAD_BEEF, 0, "dbg_bad");
    endtask

    task automatic test_timeout();
        run_txn(0, 0, 8'h0C, 32'd0, -1, "timeout");
    endtask

    // Both requesters contend; CPU drops out after two acks, debug after three.
    task automatic test_arbitration();
        int order[3];
        int want[3];
        int n, cyc;
        bit stall_ok, data_ok;
`ifdef DMEM_ARB_RR_EN
        want[0] = 1; want[1] = 2; want[2] = 2;
`else
        want[0] = 1; want[1] = 1; want[2] = 2;
`endif
        order[0] = 0; order[1] = 0; order[2] = 0;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        mem_delay = 0;
        cpu_we = 0; cpu_addr = 8'h04; dbg_we = 0; dbg_addr = 8'h08;
        cpu_req = 1; dbg_req = 1;
        n = 0; cyc = 0; stall_ok = 1; data_ok = 1;
        while (n < 3 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (cpu_req && !cpu_ack_o && cpu_stall_o !== 1'b1) stall_ok = 0;
            if (cpu_ack_o || dbg_ack_o) begin
                order[n] = (cpu_ack_o ? 1 : 0) + (dbg_ack_o ? 2 : 0);
                if (cpu_ack_o && (cpu_rdata_o !== exp_mem[1] || cpu_err_o)) data_ok = 0;
                if (dbg_ack_o && (dbg_rdata_o !== exp_mem[2] || dbg_err_o)) data_ok = 0;
                n++;
                @(posedge clk); #1;
                if (n == 2) cpu_req = 0;
                if (n == 3) begin cpu_req = 0; dbg_req = 0; end
            end
        end
        cpu_req = 0; dbg_req = 0;
        for (int i = 0; i < 3; i++) begin
            ncheck++;
            if (order[i] != want[i]) $display("FAIL arb order[%0d]: got=%0d want=%0d (1=cpu 2=dbg)", i, order[i], want[i]);
            else npass++;
        end
        ncheck++;
        if (!stall_ok || !data_ok) $display("FAIL arb stall/data: stall_ok=%b data_ok=%b want 1/1", stall_ok, data_ok);
        else npass++;
    endtask

    task automatic test_reset_mid();
        bit ack_seen;
        ack_seen = 0;
        mem_delay = 5;
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h08;
        @(negedge clk);                 // request cycle
        @(negedge clk);                 // first ISSUE cycle
        if (cpu_ack_o) ack_seen = 1;
        @(posedge clk); #1 rst = 1;     // second ISSUE cycle
        @(negedge clk);
        if (cpu_ack_o) ack_seen = 1;
        @(posedge clk); #1 begin rst = 0; cpu_req = 0; end
        @(negedge clk);
        if (cpu_ack_o) ack_seen = 1;
        ncheck++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || grant_o !== 2'b00)
            $display("FAIL rst_mid state: busy=%b mem_req=%b grant=%b want 0/0/00", busy_o, mem_req_o, grant_o);
        else npass++;
        ncheck++;
        if (ack_seen) $display("FAIL rst_mid ack: got=1 want=0");
        else npass++;
        run_txn(0, 0, 8'h08, 32'd0, 1, "reissue");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 39)), $urandom, $urandom_range(0, 4), "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i] = $urandom;
            exp_mem[i] = mem[i];
        end
        test_reset();
        test_arbitration();
        test_cpu_load();
        test_dbg_store();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule
